// File: rtl/cht_ctrl_pkg.sv
// rtl/cht_ctrl_pkg.sv - shared types and constants for the cht sequencer
package cht_ctrl_pkg;

  localparam int CHAIN_A_LEN = 16;
  localparam int CHAIN_B_LEN = 8;
  localparam int CHAIN_C_LEN = 9;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_SHIFT = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    CH_A   = 2'b00,
    CH_B   = 2'b01,
    CH_C   = 2'b10,
    CH_ALL = 2'b11
  } chain_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Enable vector ordered {c, b, a}.
  function automatic logic [2:0] chain_mask(chain_e ch);
    case (ch)
      CH_A:    chain_mask = 3'b001;
      CH_B:    chain_mask = 3'b010;
      CH_C:    chain_mask = 3'b100;
      default: chain_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/cht_ctrl_cnt.sv
// rtl/cht_ctrl_cnt.sv - loadable down-counter with hold, force-zero and zero flag
module cht_ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         hold,
  input  logic         force_zero,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Never wraps below zero, even if the caller forgets to hold.
  always_comb begin
    cnt_d = cnt_q;
    if (force_zero)           cnt_d = '0;
    else if (load)            cnt_d = load_val;
    else if (!hold && !zero)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cht_seq_ctrl.sv
// rtl/cht_seq_ctrl.sv - command sequencer driving registered cht datapath strobes
module cht_seq_ctrl
  import cht_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_chain,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             stall,
  input  logic             abort,
  output logic             clr,
  output logic             load,
  output logic             shift_a,
  output logic             shift_b,
  output logic             shift_c,
  output logic [CNT_W-1:0] remaining,
  output logic             done,
  output logic             aborted,
  output logic             err
);

  state_e     state_q, state_d;
  chain_e     chain_q, chain_d;
  logic       clr_q, clr_d, load_q, load_d;
  logic [2:0] sh_q, sh_d;
  logic       done_q, done_d, aborted_q, aborted_d, err_q, err_d;

  logic             cnt_load, cnt_hold, cnt_fz, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  // Strobes are decided one edge ahead so every output is a flop.
  always_comb begin
    state_d   = state_q;
    chain_d   = chain_q;
    clr_d     = 1'b0;
    load_d    = 1'b0;
    sh_d      = 3'b000;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    err_d     = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_hold  = 1'b1;
    cnt_fz    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_CLEAR: begin
              state_d = ST_CLEAR;
              clr_d   = 1'b1;
            end
            OP_LOAD: begin
              state_d = ST_LOAD;
              load_d  = 1'b1;
            end
            OP_SHIFT: begin
              chain_d = chain_e'(cmd_chain);
              if (cmd_count == '0) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d  = ST_SHIFT;
                cnt_load = 1'b1;
                cnt_val  = cmd_count - CNT_W'(1);
                sh_d     = chain_mask(chain_e'(cmd_chain));
              end
            end
            default: begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      ST_CLEAR, ST_LOAD: begin
        state_d   = ST_DONE;
        done_d    = 1'b1;
        aborted_d = abort;
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          cnt_fz    = 1'b1;
        end else if (cnt_zero) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (!stall) begin
          cnt_hold = 1'b0;
          sh_d     = chain_mask(chain_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      chain_q   <= CH_A;
      clr_q     <= 1'b0;
      load_q    <= 1'b0;
      sh_q      <= 3'b000;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      chain_q   <= chain_d;
      clr_q     <= clr_d;
      load_q    <= load_d;
      sh_q      <= sh_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

  cht_ctrl_cnt #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .load_val   (cnt_val),
    .hold       (cnt_hold),
    .force_zero (cnt_fz),
    .cnt        (remaining),
    .zero       (cnt_zero)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign clr       = clr_q;
  assign load      = load_q;
  assign shift_a   = sh_q[0];
  assign shift_b   = sh_q[1];
  assign shift_c   = sh_q[2];
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cht_seq_ctrl.sv
// tb/tb_cht_seq_ctrl.sv - scoreboard bench for cht_seq_ctrl
module tb_cht_seq_ctrl;
  import cht_ctrl_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [1:0]       cmd_chain = 2'b00;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             stall = 1'b0;
  logic             abort = 1'b0;
  logic             clr, load, shift_a, shift_b, shift_c, done, aborted, err;
  logic [CNT_W-1:0] remaining;

  int checks = 0;
  int errors = 0;

  // Masks: bit k set when the strobe was high k cycles after acceptance.
  typedef struct {
    int id;
    int lat;
    int m_clr;
    int m_load;
    int m_a;
    int m_b;
    int m_c;
    int ab;
    int er;
    int rem_sum;
  } exp_t;

  exp_t exp_q[$];

  cht_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_chain (cmd_chain),
    .cmd_count (cmd_count),
    .stall     (stall),
    .abort     (abort),
    .clr       (clr),
    .load      (load),
    .shift_a   (shift_a),
    .shift_b   (shift_b),
    .shift_c   (shift_c),
    .remaining (remaining),
    .done      (done),
    .aborted   (aborted),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic expect_cmd(input int id, input int lat, input int m_clr, input int m_load,
                            input int m_a, input int m_b, input int m_c, input int ab,
                            input int er, input int rem_sum);
    exp_t e;
    e.id = id; e.lat = lat; e.m_clr = m_clr; e.m_load = m_load;
    e.m_a = m_a; e.m_b = m_b; e.m_c = m_c; e.ab = ab; e.er = er; e.rem_sum = rem_sum;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
  endtask

  // Returns at #1 after the accepting edge, i.e. early in cycle t+1.
  task automatic issue(input logic [1:0] op, input logic [1:0] ch, input int cnt);
    wait_ready();
    cmd_op    = op;
    cmd_chain = ch;
    cmd_count = CNT_W'(cnt);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Monitor: tracks each accepted command and scores it when done appears.
  initial begin
    bit active = 0;
    int cyc = 0;
    int m_clr = 0, m_load = 0, m_a = 0, m_b = 0, m_c = 0, rem_sum = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0;
        continue;
      end
      if (active) begin
        cyc++;
        if (cyc < 16) begin
          if (clr)     m_clr  |= (1 << cyc);
          if (load)    m_load |= (1 << cyc);
          if (shift_a) m_a    |= (1 << cyc);
          if (shift_b) m_b    |= (1 << cyc);
          if (shift_c) m_c    |= (1 << cyc);
        end
        if (shift_a || shift_b || shift_c) rem_sum += int'(remaining);
        chk("strobe_excl",
            int'(clr) + int'(load) + int'(shift_a || shift_b || shift_c) <= 1 ? 1 : 0, 1);
        if (done) begin
          active = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("cmd%0d_lat", e.id), cyc, e.lat);
            chk($sformatf("cmd%0d_clr", e.id), m_clr, e.m_clr);
            chk($sformatf("cmd%0d_load", e.id), m_load, e.m_load);
            chk($sformatf("cmd%0d_shift_a", e.id), m_a, e.m_a);
            chk($sformatf("cmd%0d_shift_b", e.id), m_b, e.m_b);
            chk($sformatf("cmd%0d_shift_c", e.id), m_c, e.m_c);
            chk($sformatf("cmd%0d_aborted", e.id), int'(aborted), e.ab);
            chk($sformatf("cmd%0d_err", e.id), int'(err), e.er);
            chk($sformatf("cmd%0d_rem_sum", e.id), rem_sum, e.rem_sum);
            chk($sformatf("cmd%0d_rem_done", e.id), int'(remaining), 0);
          end
        end
      end else if (done || err) begin
        chk("stray_done", 1, 0);
      end
      if (cmd_valid && cmd_ready) begin
        active = 1;
        cyc = 0;
        m_clr = 0; m_load = 0; m_a = 0; m_b = 0; m_c = 0; rem_sum = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    #1;
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_strobes", int'({clr, load, shift_a, shift_b, shift_c, done, aborted, err}), 0);
    chk("rst_remaining", int'(remaining), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    expect_cmd(1, 2, 'h2, 0, 0, 0, 0, 0, 0, 0);
    issue(OP_CLEAR, CH_A, 0);
    expect_cmd(2, 2, 0, 'h2, 0, 0, 0, 0, 0, 0);
    issue(OP_LOAD, CH_A, 0);

    expect_cmd(3, 6, 0, 0, 0, 'h3E, 0, 0, 0, 10);
    issue(OP_SHIFT, CH_B, 5);

    // Stall sampled on the two edges after the first shift cycle.
    expect_cmd(4, 6, 0, 0, 'h32, 'h32, 'h32, 0, 0, 3);
    issue(OP_SHIFT, CH_ALL, 3);
    stall = 1'b1;
    repeat (2) @(posedge clk);
    #1 stall = 1'b0;

    expect_cmd(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(OP_SHIFT, CH_A, 0);

    expect_cmd(6, 2, 0, 0, 'h2, 0, 0, 1, 0, 7);
    issue(OP_SHIFT, CH_A, 8);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;

    expect_cmd(7, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    issue(OP_RSVD, CH_A, 0);

    // Valid held through the whole SHIFT: re-accepted only once ready returns.
    wait_ready();
    expect_cmd(8, 3, 0, 0, 0, 0, 'h6, 0, 0, 1);
    expect_cmd(9, 3, 0, 0, 0, 0, 'h6, 0, 0, 1);
    cmd_op = OP_SHIFT; cmd_chain = CH_C; cmd_count = CNT_W'(2);
    cmd_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 cmd_valid = 1'b0;

    // Reset in the middle of a long shift: no done may follow.
    issue(OP_SHIFT, CH_A, 10);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_strobes", int'({clr, load, shift_a, shift_b, shift_c, done}), 0);
    chk("midrst_remaining", int'(remaining), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst_ready", int'(cmd_ready), 1);
    repeat (15) @(posedge clk);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("pending_expected", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cht_seq_ctrl.md
# cht_seq_ctrl

Sequencer for the cht shift-register datapath: accepts one command at a time over a valid/ready handshake and drives the datapath control strobes. The datapath's control strobes are clear, parallel load, and per-chain shift enables for chains A (16 stages), B (8 stages) and C (9 stages). The block sits between the host command interface and the registered cht datapath. Every datapath strobe comes from a state register, so the datapath never sees combinational paths from the host.

## Interface
- CNT_W, 8, width of shift count and remaining-count output
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; asynchronous assert, active-low (deassertion synchronised outside this block)
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  2  00 CLEAR, 01 LOAD, 10 SHIFT, 11 reserved
- cmd_chain  in  2  SHIFT target: 00 A, 01 B, 10 C, 11 all three
- cmd_count  in  CNT_W  number of shift cycles for SHIFT (ignored otherwise)
- stall  in  1  freezes an in-progress SHIFT (enables low, counter held)
- abort  in  1  terminates the current command at the next edge
- clr  out  1  datapath clear strobe
- load  out  1  datapath parallel-load strobe
- shift_a / shift_b / shift_c  out  1 each  per-chain shift enables
- remaining  out  CNT_W  shift cycles still outstanding
- done  out  1  one-cycle pulse when a command retires
- aborted  out  1  qualifies done: the command was cut short by abort
- err  out  1  one-cycle pulse when a reserved op is accepted

## Operation
- States: IDLE, CLEAR, LOAD, SHIFT, DONE. Reset state is IDLE.
- Reset values: clr, load, shift_*, done, aborted and err are 0; remaining is 0; cmd_ready is 1.
- Command acceptance:
  - A command is accepted on a cycle with cmd_valid & cmd_ready. Inputs are sampled only then.
  - cmd_ready = (state == IDLE). cmd_valid while busy is ignored and not queued.
- Transitions out of IDLE on acceptance:
  - CLEAR → CLEAR
  - LOAD → LOAD
  - SHIFT with count>0 → SHIFT, remaining = count
  - SHIFT with count=0 → DONE directly; no enable is ever raised
  - reserved op → DONE with err=1 and no strobes
- CLEAR and LOAD last one cycle, then go to DONE.
- SHIFT:
  - Each non-stalled cycle asserts the enables selected by chain and decrements remaining.
  - When remaining reaches 0, go to DONE.
  - chain=11 asserts all three enables together.
- DONE: done=1 for one cycle, then IDLE.
- Mutual exclusion: clr, load and any shift_* are never high in the same cycle.
- abort:
  - In CLEAR, LOAD or SHIFT: the strobe for that cycle is suppressed, remaining is forced to 0, the next state is DONE, and aborted=1 alongside done.
  - Ignored in IDLE and DONE.
- abort has priority over stall. stall is ignored outside SHIFT.
- Reset mid-command: all strobes drop immediately (asynchronously), the in-flight command is discarded, and no done is issued.

## Timing
- Outputs are registered, Moore style.
- If a command is accepted at edge t:
  - clr or load is high during cycle t+1.
  - done is high during cycle t+2.
  - cmd_ready is high again in cycle t+3.
- SHIFT of N with no stall: enables are high for cycles t+1..t+N, done in t+N+1, ready in t+N+2. Each stall cycle extends this by one.
- remaining shows the count after the current cycle's decrement. It reads N-1 in the first shift cycle and 0 in the last.
- Back-to-back commands are separated by at least one IDLE cycle. Peak throughput is one CLEAR per 3 cycles.

## Structure
- Package cht_ctrl_pkg holds:
  - op_e (CLEAR/LOAD/SHIFT/RSVD)
  - chain_e (A/B/C/ALL)
  - state_e
  - chain length constants (16, 8, 9) for the bench and datapath
- Sub-module cht_ctrl_cnt: a loadable down-counter with hold and force-zero inputs and a zero flag. The FSM and strobe registers stay in cht_seq_ctrl.

## Test plan
- Reset mid-command: pulse rst_n low during SHIFT of 10 on chain A → all strobes 0 immediately, no done, cmd_ready=1 after release.
- CLEAR then LOAD: send CLEAR, then LOAD → clr high exactly one cycle, done two cycles after acceptance; same timing for load; strobes never overlap.
- SHIFT chain B: count 5 → shift_b high 5 consecutive cycles, remaining reads 4,3,2,1,0, done on the next cycle, shift_a and shift_c stay 0.
- Stall and zero count: SHIFT chain ALL, count 3, stall held for 2 cycles after the first shift → 3 enable cycles spread over 5, done at t+6. Separately, count 0 → done at t+1 with no enables.
- Abort: abort asserted on the 2nd cycle of SHIFT 8 → exactly one enable cycle, remaining=0, done and aborted high together.
- Reserved op and busy input: op=11 → err and done pulse, no strobes. cmd_valid held during SHIFT → no second acceptance until cmd_ready returns.
